// File: rtl/snake_pkg.sv
// Shared types for the snake heading controller.
// TURN_COALESCE_EN selects opposite-turn tail cancel in the queue.
package snake_pkg;

  localparam int HEADING_W = 2;

  typedef enum logic [HEADING_W-1:0] {
    N = 2'd0,
    E = 2'd1,
    S = 2'd2,
    W = 2'd3
  } heading_t;

  typedef enum logic {
    L = 1'b0,
    R = 1'b1
  } turn_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/snake_heading_ctrl_if.sv
// Encoder/tick inputs and heading/step outputs of the controller.
// TURN_COALESCE_EN does not change this interface.
interface snake_heading_ctrl_if;
  import snake_pkg::*;

  logic                 rot_l_pulse;
  logic                 rot_r_pulse;
  logic                 press_pulse;
  logic                 tick;
  logic [HEADING_W-1:0] heading;
  logic                 step;
  logic                 running;
  logic [2:0]           q_count;
  logic                 drop_pulse;

  modport master (
    output rot_l_pulse, rot_r_pulse,
    output press_pulse, tick,
    input  heading, step, running,
    input  q_count, drop_pulse
  );

  modport slave (
    input  rot_l_pulse, rot_r_pulse,
    input  press_pulse, tick,
    output heading, step, running,
    output q_count, drop_pulse
  );

endinterface

// File: rtl/snake_turn_fifo.sv
// Small shift-register queue of 1-bit turns, head at index 0.
// TURN_COALESCE_EN: an opposite push cancels the tail entry.
module snake_turn_fifo #(
  parameter int QDEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic       din,
  output logic       dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       cancel
);

  logic [QDEPTH-1:0] mem_q, mem_d;
  logic [2:0]        cnt_q, cnt_d;

`ifdef TURN_COALESCE_EN
  logic tail;

  // Cancel when the push undoes the tail and that tail survives the pop
  always_comb begin
    tail = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      if (int'(cnt_q) == i + 1) tail = mem_q[i];
    cancel = push & (cnt_q != 3'd0) & (tail != din)
           & ~(pop & (cnt_q == 3'd1));
  end
`else
  assign cancel = 1'b0;
`endif

  // Pop first, then cancel or push into the freed space
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 3'd0;
    end else begin
      if (pop && cnt_q != 3'd0) begin
        for (int i = 0; i < QDEPTH - 1; i++)
          mem_d[i] = mem_q[i+1];
        cnt_d = cnt_q - 3'd1;
      end
      if (cancel) begin
        cnt_d = cnt_d - 3'd1;
      end else if (push && cnt_d < 3'(QDEPTH)) begin
        for (int i = 0; i < QDEPTH; i++)
          if (int'(cnt_d) == i) mem_d[i] = din;
        cnt_d = cnt_d + 3'd1;
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      cnt_q <= 3'd0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[0];
  assign count = cnt_q;
  assign full  = (cnt_q == 3'(QDEPTH));
  assign empty = (cnt_q == 3'd0);

endmodule

// File: rtl/snake_heading_ctrl.sv
// Run/pause FSM and heading register fed by the turn queue.
// TURN_COALESCE_EN enables tail cancel in snake_turn_fifo.
module snake_heading_ctrl
  import snake_pkg::*;
#(
  parameter int                   QDEPTH      = 2,
  parameter logic [HEADING_W-1:0] HEADING_RST = 2'd1
) (
  input  logic clk,
  input  logic rst,
  snake_heading_ctrl_if.slave io
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_PAUSE = PAUSE;

  logic [1:0]           state_q, state_d;
  logic [HEADING_W-1:0] heading_q, heading_d;
  logic                 step_q, step_d;
  logic                 drop_q, drop_d;

  logic       is_run, tick_ok, push_ok;
  logic       pop, flush;
  logic       f_head, f_full, f_empty, f_cancel;
  logic [2:0] f_count;

  // A press in the same cycle wins over tick and turns
  always_comb begin
    is_run  = (state_q == ST_RUN);
    tick_ok = is_run & io.tick & ~io.press_pulse;
    push_ok = is_run & ~io.press_pulse
            & (io.rot_l_pulse ^ io.rot_r_pulse);
    pop     = tick_ok & ~f_empty;
    flush   = is_run & io.press_pulse;
  end

  snake_turn_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .flush (flush),
    .din   (io.rot_r_pulse),
    .dout  (f_head),
    .count (f_count),
    .full  (f_full),
    .empty (f_empty),
    .cancel(f_cancel)
  );

  // Press advances IDLE->RUN, RUN<->PAUSE
  always_comb begin
    state_d = state_q;
    if (io.press_pulse) begin
      unique case (1'b1)
        state_q == ST_IDLE:  state_d = ST_RUN;
        state_q == ST_RUN:   state_d = ST_PAUSE;
        state_q == ST_PAUSE: state_d = ST_RUN;
        default:             state_d = ST_IDLE;
      endcase
    end
  end

  // Apply the popped turn together with the step strobe
  always_comb begin
    heading_d = heading_q;
    if (pop)
      heading_d = (f_head == R) ? heading_q + 2'd1
                                : heading_q - 2'd1;
    step_d = tick_ok;
    drop_d = push_ok & f_full & ~pop & ~f_cancel;
  end

  // Controller registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      heading_q <= HEADING_RST;
      step_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      step_q    <= step_d;
      drop_q    <= drop_d;
    end
  end

  assign io.heading    = heading_q;
  assign io.step       = step_q;
  assign io.running    = is_run;
  assign io.q_count    = f_count;
  assign io.drop_pulse = drop_q;

endmodule

// File: tb/tb_snake_heading_ctrl.sv
// Scoreboard bench: expected step headings queued at tick time.
// Covers both builds of TURN_COALESCE_EN.
module tb_snake_heading_ctrl;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snake_heading_ctrl_if io();

  snake_heading_ctrl #(
    .QDEPTH     (2),
    .HEADING_RST(2'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  int vectors = 0;
  int miss = 0;
  logic [1:0] sb[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic apply(logic l, logic r, logic p, logic t);
    io.rot_l_pulse = l;
    io.rot_r_pulse = r;
    io.press_pulse = p;
    io.tick        = t;
    @(posedge clk);
    #1;
    io.rot_l_pulse = 1'b0;
    io.rot_r_pulse = 1'b0;
    io.press_pulse = 1'b0;
    io.tick        = 1'b0;
  endtask

  task automatic tick_exp(logic [1:0] h);
    sb.push_back(h);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every step must match the next queued heading
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (io.step === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miss++;
          $display("FAIL step_unexp: got step hd=%0d want none",
                   io.heading);
        end else begin
          e = sb.pop_front();
          chk("step_heading", io.heading, e);
        end
      end
    end
  end

  initial begin
    io.rot_l_pulse = 1'b0;
    io.rot_r_pulse = 1'b0;
    io.press_pulse = 1'b0;
    io.tick        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_heading", io.heading, 1);
    chk("rst_running", io.running, 0);
    chk("rst_qcount", io.q_count, 0);
    chk("rst_step", io.step, 0);
    chk("rst_drop", io.drop_pulse, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // idle ignores turns and ticks
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    chk("idle_q", io.q_count, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    chk("run_running", io.running, 1);
    tick_exp(2'd1);
    chk("empty_tick_q", io.q_count, 0);

    // R,R then two ticks
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rr_q1", io.q_count, 1);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rr_q2", io.q_count, 2);
    tick_exp(2'd2);
    chk("rr_pop_q1", io.q_count, 1);
    tick_exp(2'd3);
    chk("rr_pop_q0", io.q_count, 0);

    // wrap both ways
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    tick_exp(2'd0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    tick_exp(2'd3);

    // conflict pushes nothing
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    chk("conflict_q", io.q_count, 0);
    chk("conflict_drop", io.drop_pulse, 0);

    // full queue drop
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_nodrop", io.drop_pulse, 0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_drop", io.drop_pulse, 1);
    chk("full_q", io.q_count, 2);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_single", io.drop_pulse, 0);
    sb.push_back(2'd0);
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    chk("pushpop_drop", io.drop_pulse, 0);
    chk("pushpop_q", io.q_count, 2);

    // pause flushes and freezes
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pause_q", io.q_count, 0);
    chk("pause_running", io.running, 0);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pause_turn_q", io.q_count, 0);
    chk("pause_heading", io.heading, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume_running", io.running, 1);
    tick_exp(2'd0);

    // press with tick and turn: no step, push lost
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1);
    chk("presstick_q", io.q_count, 0);
    chk("presstick_run", io.running, 0);
    apply(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pausetick_run", io.running, 1);
    chk("pausetick_hd", io.heading, 0);

    // opposite turns
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef TURN_COALESCE_EN
    chk("coalesce_q", io.q_count, 0);
    chk("coalesce_drop", io.drop_pulse, 0);
    tick_exp(2'd0);
`else
    chk("rl_q", io.q_count, 2);
    tick_exp(2'd1);
    tick_exp(2'd0);
`endif

    // async reset mid-run right after a step
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    tick_exp(2'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_step", io.step, 0);
    chk("arst_heading", io.heading, 1);
    chk("arst_q", io.q_count, 0);
    chk("arst_running", io.running, 0);
    chk("arst_drop", io.drop_pulse, 0);
    repeat (3) @(negedge clk);
    chk("arst_hold_step", io.step, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_after_run", io.running, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miss);
    $finish;
  end

endmodule
